// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port and VGA pin bundle between the frame reader and its surroundings.
// master = the frame reader; slave = frame-buffer RAM plus DAC/connector side.
interface vga_frame_reader_if;
    logic [18:0] read_addr;
    logic [11:0] read_data;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        frame_start;

    modport master (
        output read_addr,
        input  read_data,
        output vga_r, vga_g, vga_b,
        output vga_hs, vga_vs,
        output frame_start
    );

    modport slave (
        input  read_addr,
        output read_data,
        input  vga_r, vga_g, vga_b,
        input  vga_hs, vga_vs,
        input  frame_start
    );
endinterface

// File: rtl/vga_frame_reader.sv
// VGA raster timing plus frame-buffer scan-out: counters and address at stage 0,
// RAM read at stage 1, colour and syncs registered together at stage 2.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic clk,
    input  logic rst,
    input  logic show_en,
    vga_frame_reader_if.master fb
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } stage_t;

    localparam stage_t STAGE_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

    // run_q holds the raster at (0,0) for the first edge after reset, so that
    // edge is the one that starts stage 0 of the first frame.
    logic          run_q;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [18:0]   addr_q, addr_d;
    logic          fs_q, fs_d;
    stage_t        s0, s1_q;
    logic [11:0]   rgb_q, rgb_d;
    logic          hs2_q, vs2_q;
    logic          h_wrap, v_wrap;

    assign h_wrap = (h_cnt_q == H_LAST);
    assign v_wrap = (v_cnt_q == V_LAST);

    always_comb begin
        s0.act = run_q && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        s0.hs  = !(run_q && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        s0.vs  = !(run_q && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    end

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        addr_d  = addr_q;
        if (run_q) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
            end
            // Row-major address is just a running count of active pixels.
            if (h_wrap && v_wrap)
                addr_d = '0;
            else if (s0.act)
                addr_d = addr_q + 19'd1;
        end
        fs_d  = (h_cnt_d == '0) && (v_cnt_d == '0);
        rgb_d = (s1_q.act && show_en) ? fb.read_data : 12'h000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q   <= 1'b0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            addr_q  <= '0;
            fs_q    <= 1'b0;
            s1_q    <= STAGE_IDLE;
            rgb_q   <= 12'h000;
            hs2_q   <= 1'b1;
            vs2_q   <= 1'b1;
        end else begin
            run_q   <= 1'b1;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            addr_q  <= addr_d;
            fs_q    <= fs_d;
            s1_q    <= s0;
            rgb_q   <= rgb_d;
            hs2_q   <= s1_q.hs;
            vs2_q   <= s1_q.vs;
        end
    end

    assign fb.read_addr   = addr_q;
    assign fb.frame_start = fs_q;
    assign fb.vga_r       = rgb_q[11:8];
    assign fb.vga_g       = rgb_q[7:4];
    assign fb.vga_b       = rgb_q[3:0];
    assign fb.vga_hs      = hs2_q;
    assign fb.vga_vs      = vs2_q;
endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader on a shrunken 15x8-clock raster (8x4 visible).
// Cycle t counts from the first edge after reset release (stage 0 at h=0,v=0).
module tb_vga_frame_reader;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;  // 15
    localparam int VT = VA + VF + VS + VB;  // 8
    localparam int FT = HT * VT;            // 120

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic show_en = 1'b1;
    logic frc = 1'b0;

    vga_frame_reader_if vif();

    vga_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .show_en(show_en),
        .fb(vif)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: one-cycle latency, data = addr[11:0] unless forced to white.
    always @(posedge clk) vif.read_data <= frc ? 12'hFFF : vif.read_addr[11:0];

    int n_cmp = 0;
    int n_bad = 0;
    int cur_t = 0;
    int first_hs;
    int fs_cnt;
    bit en_h [0:511];
    bit frc_h[0:511];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d: got %0h, want %0h", tag, cur_t, got, exp);
        end
    endtask

    function automatic int ex_addr(input int t);
        int h = t % HT;
        int v = (t / HT) % VT;
        if (v < VA) return v * HA + ((h < HA) ? h : HA);
        return HA * VA;
    endfunction

    function automatic bit ex_act(input int t);
        return ((t % HT) < HA) && (((t / HT) % VT) < VA);
    endfunction

    task automatic chk_rst(input string tag);
        chk({tag, "_addr"}, 32'(vif.read_addr), 32'd0);
        chk({tag, "_rgb"},  32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'd0);
        chk({tag, "_hs"},   32'(vif.vga_hs), 32'd1);
        chk({tag, "_vs"},   32'(vif.vga_vs), 32'd1);
        chk({tag, "_fs"},   32'(vif.frame_start), 32'd0);
    endtask

    // sched=1: frame 1 blanks line 2 via show_en, frame 2 forces RAM data to FFF.
    task automatic run(input int n, input bit sched);
        int s, e_hs, e_vs, e_rgb;
        first_hs = -1;
        fs_cnt   = 0;
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            cur_t = t;
            chk("addr", 32'(vif.read_addr), 32'(ex_addr(t)));
            chk("fs", 32'(vif.frame_start), ((t % FT) == 0) ? 32'd1 : 32'd0);
            if (vif.frame_start) fs_cnt++;
            if (!vif.vga_hs && first_hs < 0) first_hs = t;
            s = t - 2;
            if (s < 0) begin
                e_hs = 1; e_vs = 1; e_rgb = 0;
            end else begin
                e_hs  = ((s % HT) >= HA + HF && (s % HT) < HA + HF + HS) ? 0 : 1;
                e_vs  = (((s / HT) % VT) >= VA + VF && ((s / HT) % VT) < VA + VF + VS) ? 0 : 1;
                e_rgb = (ex_act(s) && en_h[t-1]) ? (frc_h[s] ? 32'hFFF : (ex_addr(s) & 32'hFFF)) : 0;
            end
            chk("hs",  32'(vif.vga_hs), 32'(e_hs));
            chk("vs",  32'(vif.vga_vs), 32'(e_vs));
            chk("rgb", 32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'(e_rgb));
            en_h[t]  = !(sched && t >= 1 && (((t - 1) / HT) % VT) == 2 && ((t - 1) / FT) == 1);
            frc_h[t] = sched && ((t / FT) == 2);
            show_en  = en_h[t];
            frc      = frc_h[t];
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cur_t = -1;
        chk_rst("rst0");
        @(negedge clk);
        rst = 1'b0;

        run(3 * FT, 1'b1);
        cur_t = -1;
        chk("hs_first", 32'(first_hs), 32'd12);
        chk("fs_cnt", 32'(fs_cnt), 32'd3);

        // Mid-frame reset at stage 0 (h=5, v=2) while the pins show a lit pixel.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        show_en = 1'b1;
        frc = 1'b0;
        run(36, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        cur_t = -2;
        chk_rst("arst");
        repeat (3) @(posedge clk);
        #1;
        chk_rst("arst_hold");
        @(negedge clk);
        rst = 1'b0;
        run(FT + 10, 1'b0);
        cur_t = -3;
        chk("fs_cnt2", 32'(fs_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
